// File: rtl/chan_sched.sv
// chan_sched: burst scheduler/arbiter for the FPGALink host-read channel (fx2Clk_in domain).
// Optional feature macro CHAN_SCHED_AUTOREARM_EN: continuous round-robin bursts across all sources.
module chan_sched #(
    parameter int NSRC  = 3,
    parameter int LEN_W = 16
) (
    input  logic              fx2Clk_in,
    input  logic              reset_in,
    input  logic [6:0]        chanAddr_in,
    input  logic [7:0]        chanData_in,
    input  logic              chanWrite_in,
    output logic              chanGotRoom_out,
    input  logic              chanRead_in,
    output logic [7:0]        chanData_out,
    output logic              chanGotData_out,
    input  logic [NSRC*8-1:0] srcData_in,
    input  logic [NSRC-1:0]   srcEmpty_in,
    output logic [NSRC-1:0]   srcRead_out,
    output logic              busy_out
);
    localparam logic [6:0] A_LEN_LO = 7'h40;
    localparam logic [6:0] A_LEN_HI = 7'h41;
    localparam logic [6:0] A_CMD    = 7'h42;
    localparam logic [6:0] A_STATUS = 7'h43;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len, cnt, cnt_nxt;
    logic [1:0]       active, active_nxt;
    logic             err, err_nxt, done, done_nxt;

    logic       wr_len_lo, wr_len_hi, cmd_start, cmd_abort, start_ok, rd_stat;
    logic [1:0] cmd_src, active_inc;
    logic [7:0] sel_data;
    logic       sel_empty, on_active, rd_fire;

    assign chanGotRoom_out = 1'b1;
    assign busy_out        = (state == STREAM);

    assign wr_len_lo = chanWrite_in && (chanAddr_in == A_LEN_LO);
    assign wr_len_hi = chanWrite_in && (chanAddr_in == A_LEN_HI);
    assign cmd_start = chanWrite_in && (chanAddr_in == A_CMD) && chanData_in[7] && !chanData_in[6];
    assign cmd_abort = chanWrite_in && (chanAddr_in == A_CMD) && chanData_in[6];
    assign cmd_src   = chanData_in[1:0];
    assign start_ok  = (int'({30'd0, cmd_src}) < NSRC) && (len != '0);
    assign rd_stat   = chanRead_in && (chanAddr_in == A_STATUS);

    // active can hold an out-of-range source after a rejected start, so the mux defaults to empty
    always_comb begin
        sel_data  = 8'h00;
        sel_empty = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            if (active == 2'(i)) begin
                sel_data  = srcData_in[i*8 +: 8];
                sel_empty = srcEmpty_in[i];
            end
        end
    end

    assign on_active  = (state == STREAM) && (chanAddr_in == {5'd0, active});
    assign rd_fire    = on_active && chanRead_in && !sel_empty;
    assign active_inc = (active == 2'(NSRC-1)) ? 2'd0 : active + 2'd1;

    for (genvar g = 0; g < NSRC; g++) begin : g_rd
        assign srcRead_out[g] = rd_fire && (active == 2'(g));
    end

    always_comb begin
        chanData_out    = 8'h00;
        chanGotData_out = 1'b0;
        if (chanAddr_in == A_STATUS) begin
            chanGotData_out = 1'b1;
            chanData_out    = {busy_out, done, err, 3'b000, active};
        end else if (on_active) begin
            chanGotData_out = !sel_empty;
            chanData_out    = sel_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        active_nxt = active;
        err_nxt    = err;
        done_nxt   = done;
        if (rd_stat) begin
            err_nxt  = 1'b0;
            done_nxt = 1'b0;
            if (state == DONE) state_nxt = IDLE;
        end
        case (state)
            IDLE, DONE: begin
                if (cmd_start) begin
                    // the requested source is latched even when rejected so STATUS shows it
                    active_nxt = cmd_src;
                    if (start_ok) begin
                        state_nxt = STREAM;
                        cnt_nxt   = len;
                        done_nxt  = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (cmd_start) err_nxt = 1'b1;
                if (rd_fire) begin
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        done_nxt = 1'b1;
`ifdef CHAN_SCHED_AUTOREARM_EN
                        cnt_nxt    = len;
                        active_nxt = active_inc;
`else
                        state_nxt  = DONE;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (cmd_abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge fx2Clk_in or posedge reset_in) begin
        if (reset_in) begin
            state  <= IDLE;
            cnt    <= '0;
            active <= 2'd0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;
            err    <= err_nxt;
            done   <= done_nxt;
        end
    end

    always_ff @(posedge fx2Clk_in or posedge reset_in) begin
        if (reset_in)       len <= '0;
        else if (wr_len_lo) len[7:0] <= chanData_in;
        else if (wr_len_hi) len[LEN_W-1:8] <= chanData_in[LEN_W-9:0];
    end

endmodule

// File: tb/tb_chan_sched.sv
// Directed bench for chan_sched with a behavioural FIFO per source (data = {src, read index}).
`timescale 1ns/1ps
module tb_chan_sched;
    localparam int NSRC = 3;

    logic              clk = 1'b0, rst = 1'b1;
    logic [6:0]        addr = 7'h7f;
    logic [7:0]        din = 8'h00;
    logic              wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0]        dout;
    logic              got_data, got_room, busy;
    logic [NSRC*8-1:0] src_data;
    logic [NSRC-1:0]   src_empty, src_rd;

    int asserts = 0, fails = 0;
    int rd_cnt[NSRC]   = '{default: 0};
    int load_tot[NSRC] = '{default: 0};

    chan_sched #(.NSRC(NSRC), .LEN_W(16)) dut (
        .fx2Clk_in(clk), .reset_in(rst), .chanAddr_in(addr), .chanData_in(din),
        .chanWrite_in(wr_en), .chanGotRoom_out(got_room), .chanRead_in(rd_en),
        .chanData_out(dout), .chanGotData_out(got_data), .srcData_in(src_data),
        .srcEmpty_in(src_empty), .srcRead_out(src_rd), .busy_out(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NSRC; i++)
            if (src_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_empty[i]        = (load_tot[i] == rd_cnt[i]);
            src_data[i*8 +: 8]  = {4'(i), 4'(rd_cnt[i])};
        end
    end

    task automatic fill(input int s, input int n);
        load_tot[s] = rd_cnt[s] + n;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        addr = a; din = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; addr = 7'h7f;
    endtask

    task automatic rd(input logic [6:0] a, output logic g, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        #1;
        g = got_data; d = dout;
        asserts++;
        if ($countones(src_rd) > 1) begin
            fails++; $display("FAIL onehot: srcRead_out=%b required at most one bit", src_rd);
        end
        @(negedge clk);
        rd_en = 1'b0; addr = 7'h7f;
    endtask

    task automatic test_reset();
        logic g; logic [7:0] v;
        addr = 7'h00; rd_en = 1'b1;
        repeat (2) @(negedge clk);
        asserts++;
        if (busy !== 1'b0 || src_rd !== '0 || got_room !== 1'b1) begin
            fails++; $display("FAIL reset_outputs: busy=%b rd=%b room=%b required 0 000 1", busy, src_rd, got_room);
        end
        rd_en = 1'b0; addr = 7'h7f;
        rst = 1'b0;
        @(negedge clk);
        rd(7'h43, g, v);
        asserts++;
        if (g !== 1'b1 || v !== 8'h00) begin
            fails++; $display("FAIL reset_status: got=%b data=%h required 1 00", g, v);
        end
        rd(7'h7f, g, v);
        asserts++;
        if (g !== 1'b0 || v !== 8'h00) begin
            fails++; $display("FAIL unmapped: got=%b data=%h required 0 00", g, v);
        end
    endtask

`ifndef CHAN_SCHED_AUTOREARM_EN
    task automatic test_single_burst();
        logic g; logic [7:0] v; int b;
        fill(1, 6); b = rd_cnt[1];
        wr(7'h40, 8'd4); wr(7'h41, 8'd0); wr(7'h42, 8'h81);
        #1 asserts++;
        if (busy !== 1'b1) begin fails++; $display("FAIL burst_busy: busy=%b required 1", busy); end
        for (int k = 0; k < 6; k++) begin
            rd(7'h01, g, v);
            if (k == 0) begin
                asserts++;
                if (g !== 1'b1 || v !== 8'h10) begin
                    fails++; $display("FAIL burst_first: got=%b data=%h required 1 10", g, v);
                end
            end
            if (k == 4) begin
                asserts++;
                if (g !== 1'b0 || v !== 8'h00) begin
                    fails++; $display("FAIL burst_after: got=%b data=%h required 0 00", g, v);
                end
            end
        end
        asserts++;
        if (rd_cnt[1] - b !== 4) begin fails++; $display("FAIL burst_count: %0d reads required 4", rd_cnt[1] - b); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h41) begin fails++; $display("FAIL burst_status1: %h required 41", v); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h01) begin fails++; $display("FAIL burst_status2: %h required 01", v); end
    endtask

    task automatic test_isolation();
        logic g; logic [7:0] v; int b0, b2;
        fill(0, 3); fill(2, 3); b0 = rd_cnt[0]; b2 = rd_cnt[2];
        wr(7'h40, 8'd2); wr(7'h42, 8'h80);
        for (int k = 0; k < 3; k++) begin
            rd(7'h02, g, v);
            asserts++;
            if (g !== 1'b0 || v !== 8'h00) begin
                fails++; $display("FAIL iso_ch2: got=%b data=%h required 0 00", g, v);
            end
        end
        asserts++;
        if (rd_cnt[2] !== b2) begin fails++; $display("FAIL iso_rd2: %0d reads required 0", rd_cnt[2] - b2); end
        rd(7'h00, g, v); rd(7'h00, g, v);
        asserts++;
        if (rd_cnt[0] - b0 !== 2) begin fails++; $display("FAIL iso_rd0: %0d reads required 2", rd_cnt[0] - b0); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h40) begin fails++; $display("FAIL iso_status: %h required 40", v); end
    endtask

    task automatic test_errors();
        logic g; logic [7:0] v; int b0;
        wr(7'h42, 8'h83);
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h23) begin fails++; $display("FAIL err_src: %h required 23", v); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h03) begin fails++; $display("FAIL err_clear: %h required 03", v); end
        wr(7'h40, 8'd0); wr(7'h42, 8'h80);
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h20) begin fails++; $display("FAIL err_len0: %h required 20", v); end
        fill(0, 10); b0 = rd_cnt[0];
        wr(7'h40, 8'd5); wr(7'h42, 8'h80);
        rd(7'h00, g, v); rd(7'h00, g, v);
        wr(7'h42, 8'h81);
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'hA0) begin fails++; $display("FAIL err_stream: %h required a0", v); end
        rd(7'h00, g, v); rd(7'h00, g, v); rd(7'h00, g, v);
        #1 asserts++;
        if (busy !== 1'b0 || rd_cnt[0] - b0 !== 5) begin
            fails++; $display("FAIL err_cnt_kept: busy=%b reads=%0d required 0 5", busy, rd_cnt[0] - b0);
        end
        rd(7'h00, g, v);
        asserts++;
        if (g !== 1'b0) begin fails++; $display("FAIL err_after: got=%b required 0", g); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h40) begin fails++; $display("FAIL err_done: %h required 40", v); end
    endtask

    task automatic test_empty_stall();
        logic g; logic [7:0] v; int b0;
        fill(0, 2); b0 = rd_cnt[0];
        wr(7'h40, 8'd5); wr(7'h42, 8'h80);
        rd(7'h00, g, v); rd(7'h00, g, v);
        for (int k = 0; k < 3; k++) begin
            rd(7'h00, g, v);
            asserts++;
            if (g !== 1'b0 || src_rd !== '0 || busy !== 1'b1) begin
                fails++; $display("FAIL stall: got=%b rd=%b busy=%b required 0 000 1", g, src_rd, busy);
            end
        end
        fill(0, 3);
        for (int k = 0; k < 3; k++) begin
            rd(7'h00, g, v);
            asserts++;
            if (g !== 1'b1) begin fails++; $display("FAIL resume: got=%b required 1", g); end
        end
        #1 asserts++;
        if (busy !== 1'b0 || rd_cnt[0] - b0 !== 5) begin
            fails++; $display("FAIL stall_end: busy=%b reads=%0d required 0 5", busy, rd_cnt[0] - b0);
        end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h40) begin fails++; $display("FAIL stall_status: %h required 40", v); end
    endtask
`else
    task automatic test_autorearm();
        logic g; logic [7:0] v; int b[NSRC];
        logic [6:0] seq [8] = '{7'h02, 7'h02, 7'h00, 7'h00, 7'h01, 7'h01, 7'h02, 7'h02};
        for (int i = 0; i < NSRC; i++) begin fill(i, 10); b[i] = rd_cnt[i]; end
        wr(7'h40, 8'd2); wr(7'h41, 8'd0); wr(7'h42, 8'h82);
        for (int k = 0; k < 8; k++) begin
            rd(seq[k], g, v);
            asserts++;
            if (g !== 1'b1 || busy !== 1'b1) begin
                fails++; $display("FAIL rearm_step%0d: got=%b busy=%b required 1 1", k, g, busy);
            end
        end
        rd(7'h02, g, v);
        asserts++;
        if (g !== 1'b0) begin fails++; $display("FAIL rearm_old_src: got=%b required 0", g); end
        asserts++;
        if (rd_cnt[0] - b[0] !== 2 || rd_cnt[1] - b[1] !== 2 || rd_cnt[2] - b[2] !== 4) begin
            fails++; $display("FAIL rearm_counts: %0d %0d %0d required 2 2 4",
                              rd_cnt[0] - b[0], rd_cnt[1] - b[1], rd_cnt[2] - b[2]);
        end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'hC0) begin fails++; $display("FAIL rearm_status: %h required c0", v); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h80) begin fails++; $display("FAIL rearm_status2: %h required 80", v); end
        wr(7'h42, 8'h40);
        #1 asserts++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rearm_abort: busy=%b required 0", busy); end
    endtask
`endif

    task automatic test_abort();
        logic g; logic [7:0] v;
        fill(0, 10);
        wr(7'h40, 8'd5); wr(7'h42, 8'h80);
        rd(7'h00, g, v);
        wr(7'h42, 8'hC0);
        #1 asserts++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: busy=%b required 0", busy); end
        rd(7'h00, g, v);
        asserts++;
        if (g !== 1'b0) begin fails++; $display("FAIL abort_got: got=%b required 0", g); end
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h00) begin fails++; $display("FAIL abort_status: %h required 00", v); end
    endtask

    task automatic test_reset_mid();
        logic g; logic [7:0] v; int b0;
        fill(0, 10);
        wr(7'h40, 8'd5); wr(7'h42, 8'h80);
        rd(7'h00, g, v);
        addr = 7'h00; rd_en = 1'b1;
        #2 rst = 1'b1;
        #1 asserts++;
        if (busy !== 1'b0 || src_rd !== '0) begin
            fails++; $display("FAIL rst_mid: busy=%b rd=%b required 0 000", busy, src_rd);
        end
        b0 = rd_cnt[0];
        repeat (2) @(negedge clk);
        asserts++;
        if (rd_cnt[0] !== b0) begin fails++; $display("FAIL rst_noread: %0d reads required 0", rd_cnt[0] - b0); end
        rd_en = 1'b0; addr = 7'h7f; rst = 1'b0;
        @(negedge clk);
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h00) begin fails++; $display("FAIL rst_status: %h required 00", v); end
        wr(7'h42, 8'h80);
        rd(7'h43, g, v);
        asserts++;
        if (v !== 8'h20) begin fails++; $display("FAIL rst_len_cleared: %h required 20", v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef CHAN_SCHED_AUTOREARM_EN
        test_autorearm();
`else
        test_single_burst();
        test_isolation();
        test_errors();
        test_empty_stall();
`endif
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/chan_sched.md
# chan_sched

Burst scheduler and arbiter for the FPGALink host-read channel in the `fx2Clk_in` domain. It sits between `comm_fpga` and up to `NSRC` source FIFOs, such as the left camera, right camera and depth-map streams. The host programs a byte length and selects a source over the channel-write interface. The block then grants exactly that many reads from the selected FIFO and refuses data on every other data channel. A status channel reports progress and sticky errors.

## Interface
- `NSRC`, 3: number of source FIFOs; legal range 1..4.
- `LEN_W`, 16: burst length counter width; must be greater than 8 and at most 16.

- `fx2Clk_in`, input, 1: the single clock, 48 MHz.
- `reset_in`, input, 1: asynchronous, active-high reset.
- `chanAddr_in`, input, 7: channel address from `comm_fpga`.
- `chanData_in`, input, 8: host write data.
- `chanWrite_in`, input, 1: host write strobe.
- `chanGotRoom_out`, output, 1: always 1; writes are never stalled.
- `chanRead_in`, input, 1: host read strobe.
- `chanData_out`, output, 8: read data, combinational mux.
- `chanGotData_out`, output, 1: data available on `chanAddr_in`.
- `srcData_in`, input, NSRC*8: FIFO outputs; source *i* is on bits [8i+7:8i].
- `srcEmpty_in`, input, NSRC: FIFO empty flags.
- `srcRead_out`, output, NSRC: FIFO read enables.
- `busy_out`, output, 1: high while state is STREAM.

## Operation
- Channel map:
  - 0..NSRC-1: data channels.
  - 0x40: LEN[7:0], write.
  - 0x41: LEN[LEN_W-1:8], write; unused upper bits are ignored.
  - 0x42: CMD, write. Bit 7 = start, bit 6 = abort, bits [1:0] = source.
  - 0x43: STATUS, read.
- STATUS byte: {busy, done, err, 3'b000, active[1:0]}.
- States are IDLE, STREAM and DONE.
- IDLE → STREAM on a CMD write when start=1, abort=0, src<NSRC and LEN≠0. This loads `cnt`=LEN and `active`=src.
- A start with src≥NSRC or LEN=0 sets `err` and stays in IDLE.
- STREAM behaviour:
  - `chanGotData_out` = ~`srcEmpty_in[active]` when `chanAddr_in`==`active`.
  - `srcRead_out[active]` = `chanRead_in` & (`chanAddr_in`==`active`) & ~`srcEmpty_in[active]`.
  - Each such read decrements `cnt`. The read taken when `cnt`==1 moves the state to DONE on the same edge.
- DONE: sets `done`. A STATUS read or a new valid start leaves DONE; a new start goes directly to STREAM.
- A start received in STREAM is ignored and sets `err`.
- Abort=1 in any state → IDLE and clears `cnt`. Abort takes priority over start when both bits are set.
- Data channels other than `active`, and all data channels outside STREAM: `chanGotData_out`=0, `srcRead_out`=0, `chanData_out`=0x00.
- STATUS channel: `chanGotData_out`=1 always. A read clears `err`, and clears `done` by going DONE→IDLE.
- Unmapped addresses: `chanGotData_out`=0, `chanData_out`=0x00; writes are dropped.
- At most one `srcRead_out` bit is high in any cycle.

## Timing
- Reset values:
  - State IDLE; `cnt`=0; LEN=0; `active`=0; `err`=0; `done`=0.
  - `busy_out`=0 and `srcRead_out`=0.
- Reset asserted mid-burst returns the block to IDLE immediately, with no further FIFO reads.
- `chanData_out`, `chanGotData_out` and `srcRead_out` are combinational from the current state and inputs. Zero latency is required because `comm_fpga` samples data in the same cycle as `chanRead`.
- Register writes take effect on the next rising edge.
- A LEN write and a CMD start in consecutive cycles use the new LEN.
- The last read in STREAM raises `busy_out` low on the following cycle.
- A STATUS read in the same cycle as the final data read cannot occur, because there is one address per cycle.

## Configuration
- `CHAN_SCHED_AUTOREARM_EN` defined: on burst completion the block skips DONE and reloads `cnt`=LEN with `active`=(`active`+1) mod NSRC. This gives a continuous round-robin frame scan. `done` pulses into the sticky bit, and abort is the only exit.
- `CHAN_SCHED_AUTOREARM_EN` undefined: the block stops in DONE as described above.

## Test plan
- Single burst: LEN=4, CMD=0x81, FIFO1 holds 6 bytes, host reads channel 1.
  - Exactly 4 `srcRead_out[1]` pulses occur.
  - After that, `chanGotData_out`=0 on channel 1.
  - STATUS reads 0x41 (done, active=1), then 0x01.
- Isolation: while streaming source 0, the host addresses channel 2 with FIFO2 non-empty. `chanGotData_out`=0 and `srcRead_out[2]` never pulses.
- Errors:
  - CMD=0x83 with NSRC=3 gives STATUS 0x23.
  - LEN=0 followed by start sets `err`.
  - A start during STREAM sets `err` and leaves `cnt` unchanged.
- Empty stall: FIFO0 goes empty mid-burst with `cnt`=3. `chanGotData_out`=0 and `cnt` holds; the burst resumes on refill.
- Abort and reset: CMD=0xC0 mid-burst returns to IDLE and `busy_out`=0 the next cycle. Asserting `reset_in` mid-burst clears all state asynchronously.
- Auto-rearm (macro defined): LEN=2, start src 2. Two reads are taken on source 2, then two on source 0, then source 1, repeating without host writes.
